iir_stream_sequencer: RTL and testbench

//  Wishbone master that streams samples through the 3-section IIR slave.
//  Per sample: takes it on a valid/ready input port, writes X (0x00), waits a

---
 rtl/iir_stream_sequencer.sv | 118 +++++++++++
 tb/tb_iir_stream_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/iir_stream_sequencer.sv
// iir_stream_sequencer: Wishbone master streaming samples through the IIR slave (X write, settle, Y read).
// Define IIR_SEQ_STATUS_POLL_EN to add a STATUS read that reports per-sample overflow on m_ovf_o.
module iir_stream_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  enable_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_ovf_o,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [DATA_WIDTH-1:0] wbm_dat_o,
    input  logic [DATA_WIDTH-1:0] wbm_dat_i,
    output logic                  wbm_we_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_cyc_o,
    input  logic                  wbm_ack_i,
    output logic                  busy_o,
    output logic                  err_o,
    input  logic                  clr_err_i,
    output logic [CNT_WIDTH-1:0]  sample_cnt_o
);
    typedef enum logic [2:0] {
        IDLE, WR_X, SETTLE, RD_Y,
`ifdef IIR_SEQ_STATUS_POLL_EN
        RD_ST,
`endif
        OUT
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYCLES - 1);

    state_t                state, next;
    logic [DATA_WIDTH-1:0] sample;
    logic [15:0]           settle_cnt, to_cnt;
    logic                  access, timeout, accept;

    assign s_ready_o = state == IDLE && enable_i && !wb_rst_i;
    assign accept    = s_ready_o && s_valid_i;
    assign m_valid_o = state == OUT;
    assign busy_o    = state != IDLE;
    assign wbm_cyc_o = access;
    assign wbm_stb_o = access;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) state <= IDLE;
        else          state <= next;

    always_comb begin
        next      = state;
        access    = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_adr_o = '0;
        wbm_dat_o = '0;
        case (state)
            IDLE:   next = accept ? WR_X : IDLE;
            WR_X: begin
                access    = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_dat_o = sample;
                next      = wbm_ack_i ? SETTLE : WR_X;
            end
            SETTLE: next = settle_cnt == SETTLE_LAST ? RD_Y : SETTLE;
            RD_Y: begin
                access    = 1'b1;
                wbm_adr_o = ADDR_WIDTH'(4);
`ifdef IIR_SEQ_STATUS_POLL_EN
                next      = wbm_ack_i ? RD_ST : RD_Y;
            end
            RD_ST: begin
                access    = 1'b1;
                wbm_adr_o = ADDR_WIDTH'(8);
`endif
                next      = wbm_ack_i ? OUT : state;
            end
            OUT:    next = m_ready_i ? IDLE : OUT;
            default: next = IDLE;
        endcase
        timeout = access && !wbm_ack_i && to_cnt == TO_LAST;
        // An expired access abandons the sample entirely
        if (timeout) next = IDLE;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            sample       <= '0;
            m_data_o     <= '0;
            settle_cnt   <= '0;
            to_cnt       <= '0;
            sample_cnt_o <= '0;
            err_o        <= 1'b0;
        end else begin
            if (accept) sample <= s_data_i;
            if (state == RD_Y && wbm_ack_i) m_data_o <= wbm_dat_i;
            settle_cnt <= state == SETTLE ? settle_cnt + 16'd1 : '0;
            to_cnt     <= access && !wbm_ack_i ? to_cnt + 16'd1 : '0;
            if (m_valid_o && m_ready_i) sample_cnt_o <= sample_cnt_o + 1'b1;
            err_o <= clr_err_i ? 1'b0 : timeout ? 1'b1 : err_o;
        end

`ifdef IIR_SEQ_STATUS_POLL_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i)                         m_ovf_o <= 1'b0;
        else if (state == RD_ST && wbm_ack_i) m_ovf_o <= wbm_dat_i[3];
`else
    assign m_ovf_o = 1'b0;
`endif
endmodule

// File: tb/tb_iir_stream_sequencer.sv
// tb_iir_stream_sequencer: randomized bench with a Wishbone slave model and a per-sample transaction model.
module tb_iir_stream_sequencer;
`ifdef IIR_SEQ_STATUS_POLL_EN
    localparam bit POLL = 1'b1;
`else
    localparam bit POLL = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
    logic        clr_err = 1'b0, ack = 1'b0, no_ack = 1'b0;
    logic [31:0] s_data = '0, y_val = '0, st_val = '0, rdat, m_data, wdat;
    logic        s_ready, m_valid, m_ovf, we, stb, cyc, busy, err;
    logic [7:0]  adr;
    logic [15:0] cnt, exp_cnt = '0;
    int          ack_delay = 0, wait_cnt = 0, checks = 0, failures = 0;
    logic [40:0] log_q[$];

    iir_stream_sequencer dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(enable),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_ovf_o(m_ovf),
        .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_dat_i(rdat), .wbm_we_o(we),
        .wbm_stb_o(stb), .wbm_cyc_o(cyc), .wbm_ack_i(ack),
        .busy_o(busy), .err_o(err), .clr_err_i(clr_err), .sample_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    // Slave: registered ack ack_delay cycles after the first strobed cycle's edge
    assign rdat = adr == 8'h04 ? y_val : adr == 8'h08 ? st_val : 32'hdead_beef;

    always @(posedge clk or posedge rst)
        if (rst) begin
            ack <= 1'b0;
            wait_cnt <= 0;
        end else if (stb && !ack && !no_ack) begin
            ack <= wait_cnt == ack_delay;
            wait_cnt <= wait_cnt == ack_delay ? 0 : wait_cnt + 1;
        end else begin
            ack <= 1'b0;
            wait_cnt <= 0;
        end

    always @(posedge clk)
        if (!rst && stb && ack) log_q.push_back({we, adr, we ? wdat : 32'h0});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sample(input logic [31:0] x, y, st, input int d, hold, input logic en_after);
        int n;
        logic [40:0] e[3];
        ack_delay = d;
        y_val = y;
        st_val = st;
        e[0] = {1'b1, 8'h00, x};
        e[1] = {1'b0, 8'h04, 32'h0};
        e[2] = {1'b0, 8'h08, 32'h0};
        n = 0;
        while (!s_ready && n < 50) begin tick(); n++; end
        chk("s_ready_idle", 64'(s_ready), 64'd1);
        s_valid = 1'b1;
        s_data = x;
        tick();
        s_valid = 1'b0;
        s_data = $urandom;
        enable = en_after;
        n = 1;
        while (!m_valid && n < 200) begin tick(); n++; end
        chk("latency", 64'(n), POLL ? 64'(11 + 3 * d) : 64'(9 + 2 * d));
        chk("m_data", 64'(m_data), 64'(y));
        chk("m_ovf", 64'(m_ovf), POLL ? 64'(st[3]) : 64'd0);
        s_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold", {29'd0, m_valid, m_data, cyc, s_ready, m_ovf},
                {29'd0, 1'b1, y, 1'b0, 1'b0, POLL ? st[3] : 1'b0});
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        s_valid = 1'b0;
        exp_cnt++;
        chk("idle_after_out", 64'({busy, m_valid}), 64'd0);
        chk("sample_cnt", 64'(cnt), 64'(exp_cnt));
        chk("s_ready_after", 64'(s_ready), 64'(en_after));
        chk("access_count", 64'(log_q.size()), POLL ? 64'd3 : 64'd2);
        for (int i = 0; i < (POLL ? 3 : 2); i++)
            if (log_q.size() > 0) chk("access", 64'(log_q.pop_front()), 64'(e[i]));
        log_q.delete();
        enable = 1'b1;
    endtask

    initial begin
        int n;
        logic seen;
        // Reset with enable low: everything quiet
        repeat (2) tick();
        chk("rst_flags", 64'({s_ready, m_valid, m_ovf, we, stb, cyc, busy, err}), 64'd0);
        chk("rst_vals", {cnt, m_data, adr}, 64'd0);
        chk("rst_wdat", 64'(wdat), 64'd0);
        rst = 1'b0;
        tick();
        chk("s_ready_en0", 64'(s_ready), 64'd0);
        enable = 1'b1;
        tick();
        chk("s_ready_en1", 64'(s_ready), 64'd1);

        run_sample(32'h0010_0000, 32'h0000_1234, 32'h0, 0, 0, 1'b1);
        run_sample(32'h0020_0000, 32'h0000_5678, 32'h0, 0, 10, 1'b1);
        run_sample(32'h0030_0000, 32'h0000_9abc, 32'h8, 0, 1, 1'b1);
        run_sample(32'hffff_fff0, 32'h8000_0001, 32'h8, 1, 2, 1'b0);

        // Slave never acks the X write
        no_ack = 1'b1;
        s_valid = 1'b1;
        s_data = 32'h1357_9bdf;
        tick();
        s_valid = 1'b0;
        n = 0;
        seen = 1'b0;
        while (cyc && n < 40) begin
            n++;
            seen |= m_valid;
            tick();
        end
        no_ack = 1'b0;
        chk("timeout_strobes", 64'(n), 64'd16);
        chk("timeout_err", 64'(err), 64'd1);
        chk("timeout_s_ready", 64'(s_ready), 64'd1);
        chk("timeout_no_valid", 64'(seen), 64'd0);
        chk("timeout_no_acc", 64'(log_q.size()), 64'd0);
        chk("timeout_cnt", 64'(cnt), 64'(exp_cnt));
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_err", 64'(err), 64'd0);

        for (int k = 0; k < 16; k++)
            run_sample($urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);

        // Reset in the middle of the Y read
        s_valid = 1'b1;
        s_data = 32'h0badcafe;
        tick();
        s_valid = 1'b0;
        n = 0;
        while (!(cyc && !we) && n < 50) begin tick(); n++; end
        chk("reach_rd_y", 64'({cyc, we, adr}), 64'({2'b10, 8'h04}));
        rst = 1'b1;
        #1;
        chk("rst_mid_bus", 64'({cyc, stb, m_valid, busy}), 64'd0);
        chk("rst_mid_cnt", 64'(cnt), 64'd0);
        tick();
        rst = 1'b0;
        log_q.delete();
        exp_cnt = '0;
        tick();
        run_sample(32'h0040_0000, 32'h0000_4321, 32'h8, 0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
